pwm_multi_ch: RTL

//  Parametrised N-channel PWM generator; successor to the single-channel 10-step generator.
//  One shared prescaler and period counter; per-channel shadowed duty registers.

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_btn_debounce.sv | 41 ++++
 rtl/pwm_multi_ch.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_pkg
//  Purpose  : Shared constants, types and helpers for the multi-channel PWM.
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Ceil-log2 with a floor of one bit, so single-entry selectors stay legal.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_btn_debounce
//  Purpose  : Synchronise a raw button, sample it on a shared strobe and emit
//             a one-clock pulse on each accepted press.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_btn_debounce
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic btn,
    output logic pulse
);

    logic [1:0] r_sync;
    logic       r_sample;
    logic       r_pulse;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync   <= '0;
            r_sample <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn};
            r_pulse <= 1'b0;
            // Bounces shorter than the strobe spacing are seen at most once.
            if (stb) begin
                r_sample <= r_sync[1];
                r_pulse  <= r_sync[1] & ~r_sample;
            end
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_ch.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi_ch
//  Purpose  : N-channel PWM with shared prescaler/period counter, shadowed
//             per-channel duty and debounced inc/dec buttons.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int CH        = 4,
    parameter int RES_W     = 8,
    parameter int DUTY_INIT = 128,
    parameter int STEP      = 1,
    parameter int DEB_DIV   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [5:0]                   divisor,
    input  logic [RES_W-1:0]             period,
    input  logic                         mode,
    input  logic [CH-1:0]                ch_en,
    input  logic [clog2_min1(CH)-1:0]    sel,
    input  logic                         increase_duty,
    input  logic                         decrease_duty,
    output logic [CH-1:0]                pwm_out,
    output logic                         period_end,
    output logic [RES_W:0]               duty_rd
);

    localparam int                c_sel_w     = clog2_min1(CH);
    localparam int                c_deb_w     = clog2_min1(DEB_DIV);
    localparam logic [RES_W:0]    c_duty_init = (RES_W+1)'(DUTY_INIT);
    localparam logic [RES_W:0]    c_duty_max  = {1'b1, {RES_W{1'b0}}};
    localparam logic [RES_W:0]    c_step_n    = (RES_W+1)'(STEP);
    localparam logic [RES_W+1:0]  c_step_w    = (RES_W+2)'(STEP);

    logic [5:0]         r_presc;
    logic [RES_W-1:0]   r_cnt;
    dir_t               r_dir;
    logic [RES_W-1:0]   r_period_act;
    logic               r_mode_act;
    logic               r_period_end;
    logic [c_deb_w-1:0] r_deb_cnt;

    logic               w_tick;
    logic               w_boundary;
    logic [RES_W-1:0]   w_cnt_nxt;
    dir_t               w_dir_nxt;
    logic [RES_W-1:0]   w_restart;
    logic [RES_W:0]     w_duty_lim;
    logic               w_deb_stb;
    logic               w_inc_p;
    logic               w_dec_p;
    logic               w_upd;
    logic [c_sel_w-1:0] w_sel_idx;
    logic               w_sel_ok;
    logic [RES_W:0]     w_duty_regs [CH];
    logic [RES_W:0]     w_duty_cur;
    logic [RES_W+1:0]   w_sum;
    logic [RES_W:0]     w_duty_inc;
    logic [RES_W:0]     w_duty_dec;
    logic [RES_W:0]     w_duty_new;

    assign w_tick     = (r_presc == divisor);
    assign w_deb_stb  = (r_deb_cnt == c_deb_w'(DEB_DIV - 1));
    assign w_duty_lim = {1'b0, period} + (RES_W+1)'(1);
    // The next period starts past its own zero tick when it will run centred.
    assign w_restart  = ((mode == MODE_CENTER) && (period != '0)) ? RES_W'(1) : '0;

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = r_dir;
        w_boundary = 1'b0;
        if (w_tick) begin
            if (r_mode_act == MODE_EDGE) begin
                w_dir_nxt = DIR_UP;
                if (r_cnt >= r_period_act) begin
                    w_boundary = 1'b1;
                    w_cnt_nxt  = w_restart;
                end else begin
                    w_cnt_nxt = r_cnt + RES_W'(1);
                end
            end else if (r_period_act == '0) begin
                w_boundary = 1'b1;
                w_dir_nxt  = DIR_UP;
                w_cnt_nxt  = w_restart;
            end else if (r_dir == DIR_UP) begin
                if (r_cnt >= r_period_act) begin
                    w_dir_nxt = DIR_DOWN;
                    w_cnt_nxt = r_cnt - RES_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt + RES_W'(1);
                end
            end else begin
                if (r_cnt == '0) begin
                    w_boundary = 1'b1;
                    w_dir_nxt  = DIR_UP;
                    w_cnt_nxt  = w_restart;
                end else begin
                    w_cnt_nxt = r_cnt - RES_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc      <= '0;
            r_cnt        <= '0;
            r_dir        <= DIR_UP;
            r_period_act <= period;
            r_mode_act   <= mode;
            r_period_end <= 1'b0;
            r_deb_cnt    <= '0;
        end else begin
            r_presc      <= w_tick ? '0 : r_presc + 6'd1;
            r_cnt        <= w_cnt_nxt;
            r_dir        <= w_dir_nxt;
            r_period_end <= w_boundary;
            r_deb_cnt    <= w_deb_stb ? '0 : r_deb_cnt + c_deb_w'(1);
            if (w_boundary) begin
                r_period_act <= period;
                r_mode_act   <= mode;
            end
        end
    end

    pwm_btn_debounce u_deb_inc (
        .clk   (clk),
        .rst   (rst),
        .stb   (w_deb_stb),
        .btn   (increase_duty),
        .pulse (w_inc_p)
    );

    pwm_btn_debounce u_deb_dec (
        .clk   (clk),
        .rst   (rst),
        .stb   (w_deb_stb),
        .btn   (decrease_duty),
        .pulse (w_dec_p)
    );

    generate
        if (CH == 1) begin : g_sel_single
            assign w_sel_idx = '0;
        end else begin : g_sel_multi
            assign w_sel_idx = sel;
        end
    endgenerate

    assign w_sel_ok   = (int'(w_sel_idx) < CH);
    assign w_duty_cur = w_duty_regs[w_sel_idx];
    assign duty_rd    = w_sel_ok ? w_duty_cur : '0;

    // Simultaneous inc and dec pulses cancel out.
    assign w_upd      = w_inc_p ^ w_dec_p;
    assign w_sum      = {1'b0, w_duty_cur} + c_step_w;
    assign w_duty_inc = (w_sum > {1'b0, c_duty_max}) ? c_duty_max : w_sum[RES_W:0];
    assign w_duty_dec = (w_duty_cur < c_step_n) ? '0 : w_duty_cur - c_step_n;
    assign w_duty_new = w_inc_p ? w_duty_inc : w_duty_dec;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [RES_W:0] r_duty_reg;
            logic [RES_W:0] r_duty_act;
            logic           r_pwm;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_duty_reg <= c_duty_init;
                    r_duty_act <= c_duty_init;
                    r_pwm      <= 1'b0;
                end else begin
                    if (w_upd && (w_sel_idx == c_sel_w'(gi))) begin
                        r_duty_reg <= w_duty_new;
                    end
                    // Shadow copy only moves at the boundary, so widths never tear.
                    if (w_boundary) begin
                        r_duty_act <= (r_duty_reg < w_duty_lim) ? r_duty_reg : w_duty_lim;
                    end
                    r_pwm <= ch_en[gi] & ({1'b0, r_cnt} < r_duty_act);
                end
            end

            assign w_duty_regs[gi] = r_duty_reg;
            assign pwm_out[gi]     = r_pwm;
        end
    endgenerate

    assign period_end = r_period_end;

endmodule
`default_nettype wire
